// File: rtl/cpu_pkg.sv
// Shared fetch-side types for the instruction prefetch queue: fetch FSM states,
// instruction/PC widths and the buffered {instr, pc+4} entry layout.
package cpu_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [31:0] PC_INCR = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc4;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/pfq_fifo.sv
// Small synchronous FIFO of fetch entries with a flush input; the head entry
// is presented combinationally so the consumer sees it in the same cycle.
module pfq_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  fetch_entry_t             push_data,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [AW:0]    count_q;
    logic           do_push;
    logic           do_pop;

    // Clear wins over both ports so a flush never lets a stale word slip in.
    assign do_push = push && !clear;
    assign do_pop  = pop && !clear && (count_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(do_push && !do_pop && (count_q == FULL_CNT)));

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: runs sequential fetches ahead of IF/ID with one
// request in flight. Optional counters are built when IF_PREFETCH_STATS_EN is defined.
module if_prefetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc4,
    input  logic        redirect_valid,
`ifdef IF_PREFETCH_STATS_EN
    input  logic [31:0] redirect_pc,
    output logic [15:0] stat_flushes,
    output logic [15:0] stat_starve
`else
    input  logic [31:0] redirect_pc
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    fetch_state_e   state_q;
    logic [31:0]    fetch_pc_q;
    logic           mem_req_q;
    logic [31:0]    mem_addr_q;
    logic [CW-1:0]  count;
    fetch_entry_t   head;
    fetch_entry_t   push_entry;
    logic           push;
    logic           pop;
    logic [31:0]    target_pc;

    assign target_pc  = align_pc(redirect_pc);
    assign push       = (state_q == WAIT) && mem_ack && !redirect_valid;
    assign pop        = out_valid && out_ready && !redirect_valid;
    assign push_entry = '{instr: mem_rdata, pc4: fetch_pc_q + PC_INCR};

    // Credit check happens at issue time; with one request in flight the
    // returning word always has a free slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= target_pc;
                    end else if (count < DEPTH_CNT) begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= fetch_pc_q;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= target_pc;
                        if (mem_ack) begin
                            mem_req_q <= 1'b0;
                            state_q   <= IDLE;
                        end else begin
                            state_q   <= DRAIN;
                        end
                    end else if (mem_ack) begin
                        fetch_pc_q <= fetch_pc_q + PC_INCR;
                        mem_req_q  <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                DRAIN: begin
                    if (redirect_valid) fetch_pc_q <= target_pc;
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    pfq_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .clear     (redirect_valid),
        .push_data (push_entry),
        .count     (count),
        .head      (head)
    );

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign out_valid = (count != '0);
    assign out_instr = out_valid ? head.instr : '0;
    assign out_pc4   = out_valid ? head.pc4   : '0;

`ifdef IF_PREFETCH_STATS_EN
    logic [15:0] flushes_q;
    logic [15:0] starve_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flushes_q <= '0;
            starve_q  <= '0;
        end else begin
            if (redirect_valid && (flushes_q != 16'hFFFF))
                flushes_q <= flushes_q + 1'b1;
            if (!out_valid && out_ready && !redirect_valid && (starve_q != 16'hFFFF))
                starve_q <= starve_q + 1'b1;
        end
    end

    assign stat_flushes = flushes_q;
    assign stat_starve  = starve_q;
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: a simple memory responder plus request
// and pop logs, checked against hand-computed address/data sequences.
module tb_if_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc4;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
`ifdef IF_PREFETCH_STATS_EN
    logic [15:0] stat_flushes;
    logic [15:0] stat_starve;
`endif

    if_prefetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc4        (out_pc4),
        .redirect_valid (redirect_valid),
`ifdef IF_PREFETCH_STATS_EN
        .redirect_pc    (redirect_pc),
        .stat_flushes   (stat_flushes),
        .stat_starve    (stat_starve)
`else
        .redirect_pc    (redirect_pc)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic        mem_auto = 1'b1;
    int          mem_lat = 1;
    int          req_age = 0;
    logic        req_prev = 1'b0;
    logic [31:0] req_addrs [$];
    int          req_cycs  [$];
    logic [31:0] pop_instr [$];
    logic [31:0] pop_pc4   [$];
    int          pop_cycs  [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end else begin
            $display("ok   %s = %08h", tag, got);
        end
    endtask

    task automatic clear_logs();
        req_addrs.delete();
        req_cycs.delete();
        pop_instr.delete();
        pop_pc4.delete();
        pop_cycs.delete();
    endtask

    // One clock: log the pop about to happen, step past the edge, log a new
    // request and run the memory responder for the coming cycle.
    task automatic tick();
        if (out_valid && out_ready && !redirect_valid) begin
            pop_instr.push_back(out_instr);
            pop_pc4.push_back(out_pc4);
            pop_cycs.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (mem_req && !req_prev) begin
            req_addrs.push_back(mem_addr);
            req_cycs.push_back(cyc);
        end
        req_prev = mem_req;
        if (mem_auto) begin
            if (mem_req) req_age++;
            else         req_age = 0;
            mem_ack   = mem_req && (req_age > mem_lat);
            mem_rdata = mem_addr ^ 32'hA5A5_0000;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        mem_ack = 1'b0;
        mem_auto = 1'b1;
        mem_lat = 1;
        tick();
        tick();
        rst = 1'b0;
        req_prev = 1'b0;
        req_age = 0;
        mem_ack = 1'b0;
        clear_logs();
    endtask

    task automatic run_pops(input int n);
        for (int i = 0; i < 200 && pop_pc4.size() < n; i++) tick();
        check("pop_count_reached", 32'(pop_pc4.size() >= n), 32'd1);
    endtask

    initial begin
        int found;

        // Reset values
        do_reset();
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_pc4", out_pc4, 32'h0);
`ifdef IF_PREFETCH_STATS_EN
        check("rst_stat_flushes", 32'(stat_flushes), 32'd0);
        check("rst_stat_starve", 32'(stat_starve), 32'd0);
`endif

        // Streaming with a consumer that is always ready
        out_ready = 1'b1;
        run_pops(4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stream_addr%0d", i), req_addrs[i], 32'(4 * i));
            check($sformatf("stream_pc4_%0d", i), pop_pc4[i], 32'(4 * i + 4));
            check($sformatf("stream_instr%0d", i), pop_instr[i], 32'(4 * i) ^ 32'hA5A5_0000);
        end

        // Backpressure: exactly DEPTH requests, then a refill after the first pop
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("bp_req_count", 32'(req_addrs.size()), 32'd4);
        check("bp_mem_req_idle", 32'(mem_req), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        run_pops(4);
        for (int i = 0; i < 10 && req_addrs.size() < 5; i++) tick();
        for (int i = 0; i < 4; i++)
            check($sformatf("bp_pc4_%0d", i), pop_pc4[i], 32'(4 * i + 4));
        check("bp_refill_addr", req_addrs[4], 32'h10);
        check("bp_refill_delay", 32'(req_cycs[4] - pop_cycs[0]), 32'd1);

        // Redirect while idle with two entries queued
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 50 && !(req_addrs.size() == 2 && !mem_req); i++) tick();
        check("ri_two_queued", 32'(out_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0043;
        tick();
        redirect_valid = 1'b0;
        clear_logs();
        check("ri_flushed", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        run_pops(1);
        check("ri_next_addr", req_addrs[0], 32'h0000_0040);
        check("ri_first_pc4", pop_pc4[0], 32'h0000_0044);
        check("ri_first_instr", pop_instr[0], 32'h0000_0040 ^ 32'hA5A5_0000);

        // Redirect with a request outstanding; stale ack three cycles later
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 50 && !(req_addrs.size() == 3 && mem_req); i++) tick();
        check("rw_pending_addr", mem_addr, 32'h8);
        mem_auto = 1'b0;
        mem_ack = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        clear_logs();
        check("rw_req_held", 32'(mem_req), 32'd1);
        check("rw_addr_held", mem_addr, 32'h8);
        tick();
        tick();
        mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0;
        check("rw_req_dropped", 32'(mem_req), 32'd0);
        mem_auto = 1'b1;
        req_age = 0;
        run_pops(2);
        found = 0;
        foreach (pop_instr[i]) if (pop_instr[i] == 32'hDEAD_BEEF) found++;
        check("rw_no_stale_data", 32'(found), 32'd0);
        check("rw_next_addr", req_addrs[0], 32'h0000_0100);
        check("rw_first_pc4", pop_pc4[0], 32'h0000_0104);

        // Same again with the ack landing in the redirect cycle
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 50 && !(req_addrs.size() == 3 && mem_req); i++) tick();
        mem_auto = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        mem_ack = 1'b0;
        clear_logs();
        check("ra_req_dropped", 32'(mem_req), 32'd0);
        check("ra_flushed", 32'(out_valid), 32'd0);
        mem_auto = 1'b1;
        req_age = 0;
        run_pops(2);
        found = 0;
        foreach (pop_instr[i]) if (pop_instr[i] == 32'hDEAD_BEEF) found++;
        check("ra_no_stale_data", 32'(found), 32'd0);
        check("ra_next_addr", req_addrs[0], 32'h0000_0100);
        check("ra_first_pc4", pop_pc4[0], 32'h0000_0104);

        // Address wrap-around at the top of memory
        do_reset();
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
`ifdef IF_PREFETCH_STATS_EN
        check("wrap_stat_flushes", 32'(stat_flushes), 32'd1);
`endif
        clear_logs();
        run_pops(3);
        check("wrap_addr0", req_addrs[0], 32'hFFFF_FFF8);
        check("wrap_addr1", req_addrs[1], 32'hFFFF_FFFC);
        check("wrap_addr2", req_addrs[2], 32'h0000_0000);
        check("wrap_pc4_0", pop_pc4[0], 32'hFFFF_FFFC);
        check("wrap_pc4_1", pop_pc4[1], 32'h0000_0000);
        check("wrap_pc4_2", pop_pc4[2], 32'h0000_0004);

        // Asynchronous reset in the middle of a pending request
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 50 && req_addrs.size() < 2; i++) tick();
        mem_lat = 10;
        tick();
        tick();
        check("ar_pending_req", 32'(mem_req), 32'd1);
        check("ar_queued_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_mem_req_now", 32'(mem_req), 32'd0);
        check("ar_out_valid_now", 32'(out_valid), 32'd0);
`ifdef IF_PREFETCH_STATS_EN
        check("ar_stat_flushes", 32'(stat_flushes), 32'd0);
        check("ar_stat_starve", 32'(stat_starve), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_ack = 1'b0;
        mem_lat = 1;
        req_age = 0;
        req_prev = 1'b0;
        clear_logs();
        for (int i = 0; i < 20 && req_addrs.size() < 1; i++) tick();
        check("ar_first_req_seen", 32'(req_addrs.size()), 32'd1);
        check("ar_first_req_addr", req_addrs[0], 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
- Instruction prefetch stage between the instruction memory bank and the IF/ID pipeline register.
- Runs ahead of the pipeline: fetches sequential words through a req/ack memory handshake and buffers {instruction, pc+4} pairs in a small FIFO.
- Hands buffered pairs to IF/ID under a valid/ready handshake.
- A branch/jump redirect from the pipeline flushes the FIFO and restarts fetching at the target.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_req  out  1  fetch request to instruction memory.
- mem_addr  out  32  word address of the request; low two bits always 0.
- mem_ack  in  1  single-cycle response strobe; mem_rdata is valid in this cycle.
- mem_rdata  in  32  instruction word returned.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  IF/ID accepts the head this cycle (low while the pipeline is stalled).
- out_instr  out  32  instruction at the FIFO head.
- out_pc4  out  32  address of that instruction plus 4.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  32  restart address; bits [1:0] are ignored and forced to 0.

Behaviour:
- Reset (async, active-high):
  - fetch_pc=RESET_PC, FIFO empty, state=IDLE.
  - mem_req=0, mem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc4=0.
- States: IDLE, WAIT, DRAIN.
- IDLE → WAIT: when FIFO count < DEPTH and redirect_valid=0. Registered mem_req=1 and mem_addr=fetch_pc are visible the next cycle. At most one request is outstanding.
- Request handshake: in WAIT/DRAIN, mem_req stays 1 and mem_addr stays stable until mem_ack. A request is never withdrawn.
- WAIT on mem_ack with no redirect:
  - Push {mem_rdata, fetch_pc+4}.
  - fetch_pc += 4 (32-bit modulo; wraps FFFF_FFFC→0000_0000).
  - mem_req drops; go to IDLE.
  - Minimum issue interval is 2 cycles per word.
- Credit rule: a request issues only if count < DEPTH at issue. A push therefore never overflows. A push into a full FIFO is an assertion failure.
- Output:
  - out_valid = count != 0.
  - out_instr and out_pc4 come from the head entry, combinationally.
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle leave count unchanged.
- Redirect (redirect_valid=1), highest priority over push and pop:
  - The FIFO is cleared at the edge, so out_valid=0 in the next cycle.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - IDLE → IDLE: the request is issued the following cycle.
  - WAIT with no ack in the same cycle → DRAIN.
  - WAIT with ack in the same cycle: the response is discarded → IDLE.
  - DRAIN: stay in DRAIN and update fetch_pc again.
- DRAIN: keep the stale request asserted. On mem_ack, discard the data (no push) and go to IDLE. fetch_pc is unchanged by the stale ack.
- out_ready is ignored when out_valid=0. out_instr and out_pc4 are don't-care when out_valid=0.
- Reset mid-request: state is cleared immediately. The memory bank must tolerate a dropped mem_req.

Optional Feature:
- Macro: IF_PREFETCH_STATS_EN.
- Defined:
  - Adds output ports stat_flushes (16) and stat_starve (16). Both reset to 0 and saturate at FFFF.
  - stat_flushes: +1 per cycle with redirect_valid=1.
  - stat_starve: +1 per cycle with out_valid=0 && out_ready=1 && redirect_valid=0.
- Undefined: the ports and counters are absent; core behaviour is identical.

Decomposition:
- Shared package cpu_pkg:
  - Fetch-state enum {IDLE, WAIT, DRAIN}.
  - INSTR_W=32, PC_INCR=32'd4.
  - Fetch entry struct {instr[31:0], pc4[31:0]}.
- One sub-module: pfq_fifo.
  - Synchronous FIFO of DEPTH×64 bits with a clear input.
  - Ports: push/pop/clear, count, and head data.
  - Same clk/rst.
- The FSM and fetch_pc live in the top module.

Test Plan:
- Reset and stream:
  - Stimulus: RESET_PC=0; memory acks 1 cycle after mem_req with rdata=addr^32'hA5A5_0000; out_ready=1.
  - Required: mem_addr sequence 0,4,8,C; out_pc4 sequence 4,8,C,10 in order; out_instr matches.
- Backpressure:
  - Stimulus: out_ready=0 for 20 cycles.
  - Required: exactly DEPTH=4 requests issue; mem_req stays 0 once full.
  - On out_ready=1: entries for addrs 0..C drain, and a request at 10 issues the cycle after the first pop.
- Redirect in IDLE:
  - Stimulus: redirect_pc=32'h0000_0043 while 2 entries are queued.
  - Required: out_valid=0 the next cycle; the next mem_addr is 0000_0040; the first out_pc4 is 0000_0044.
- Redirect during an outstanding request:
  - Stimulus: request at 8 pending; redirect to 100; ack arrives 3 cycles later with 32'hDEAD_BEEF.
  - Required: DEAD_BEEF is never presented; the next request is at 100.
  - Repeat with the ack in the same cycle as the redirect: same result.
- Wrap-around:
  - Stimulus: redirect to FFFF_FFF8.
  - Required: mem_addr sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; out_pc4 sequence FFFF_FFFC, 0000_0000, 0000_0004.
- Async reset mid-WAIT:
  - Stimulus: assert rst between edges.
  - Required: mem_req=0 and out_valid=0 immediately; after release, the first request is at RESET_PC.
  - With IF_PREFETCH_STATS_EN: both counters read 0.
